// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer, press/release debounce FSM, press counter.
// Define LONG_PRESS_EN to build the long-hold detector; otherwise long_press is tied to 0.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    output logic       button_was_pressed,
    output logic       button_level,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pulse_q;
    logic [7:0]        count_q;
    logic              pressed;
    logic              accept;

    assign pressed = ~sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pressed) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                // Release takes priority over the terminal count.
                if (!pressed) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPressed: begin
                if (!pressed) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                // A renewed press is a bounce: back to PRESSED with no new pulse.
                if (pressed) begin
                    state_d = StPressed;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], key_n};
            cnt_q   <= cnt_d;
            pulse_q <= accept;
            if (accept) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign button_was_pressed = pulse_q;
    assign press_count        = count_q;
    assign button_level       = (state_q == StPressed) || (state_q == StReleaseWait);

`ifdef LONG_PRESS_EN
    localparam int unsigned LongW = $clog2(LONG_CYCLES + 1);

    logic [LongW-1:0] long_cnt_q, long_cnt_d;
    logic             long_fire;
    logic             long_q;

    // Counts only in PRESSED and saturates at LONG_CYCLES, so one pulse per press.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_fire  = 1'b0;
        if (state_q == StIdle) begin
            long_cnt_d = '0;
        end else if (state_q == StPressed && long_cnt_q != LongW'(LONG_CYCLES)) begin
            long_cnt_d = long_cnt_q + LongW'(1);
            long_fire  = (long_cnt_q == LongW'(LONG_CYCLES - 1));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_fire;
        end
    end

    assign long_press = long_q;
`else
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_CYCLES;
    assign long_press         = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_button_debounce;

    localparam int unsigned Db = 4;
    localparam int unsigned Lc = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic       bwp;
    logic       level;
    logic       lp;
    logic [7:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int longs    = 0;
    int seen;

    button_debounce #(
        .DEBOUNCE_CYCLES(Db),
        .LONG_CYCLES    (Lc)
    ) dut (
        .CLOCK_50          (clk),
        .reset             (rst),
        .key_n             (key_n),
        .button_was_pressed(bwp),
        .button_level      (level),
        .long_press        (lp),
        .press_count       (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bwp) pulses++;
        if (lp) longs++;
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 1'b1;
        repeat (3) tick();
        check("rst_bwp", int'(bwp), 0);
        check("rst_level", int'(level), 0);
        check("rst_long", int'(lp), 0);
        check("rst_count", int'(cnt), 0);
        rst = 1'b0;
        tick();

        // Clean press: pulse after edge 7 only.
        pulses = 0;
        key_n  = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 6) begin
                check("clean_bwp_e6", int'(bwp), 0);
                check("clean_level_e6", int'(level), 0);
            end
            if (e == 7) begin
                check("clean_bwp_e7", int'(bwp), 1);
                check("clean_level_e7", int'(level), 1);
                check("clean_count_e7", int'(cnt), 1);
            end
            if (e == 8) check("clean_bwp_e8", int'(bwp), 0);
        end
        check("clean_pulses", pulses, 1);
        key_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("release_level_e6", int'(level), 1);
            if (e == 7) check("release_level_e7", int'(level), 0);
        end
        repeat (2) tick();

        // Glitch of 3 cycles is rejected.
        pulses = 0;
        seen   = 0;
        key_n  = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (level) seen = 1;
        end
        check("glitch_pulses", pulses, 0);
        check("glitch_level", seen, 0);
        check("glitch_count", int'(cnt), 1);

        // Release bounce while held.
        key_n = 1'b0;
        repeat (10) tick();
        check("bounce_pre_count", int'(cnt), 2);
        pulses = 0;
        seen   = 0;
        key_n  = 1'b1;
        repeat (2) begin
            tick();
            if (!level) seen = 1;
        end
        key_n = 1'b0;
        repeat (10) begin
            tick();
            if (!level) seen = 1;
        end
        check("bounce_pulses", pulses, 0);
        check("bounce_level_drop", seen, 0);
        check("bounce_count", int'(cnt), 2);
        key_n = 1'b1;
        repeat (10) tick();

        // Long hold of 40 cycles.
        pulses = 0;
        longs  = 0;
        key_n  = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 7) check("long_bwp_e7", int'(bwp), 1);
            if (e == 22) check("long_lp_e22", int'(lp), 0);
`ifdef LONG_PRESS_EN
            if (e == 23) check("long_lp_e23", int'(lp), 1);
`else
            if (e == 23) check("long_lp_e23", int'(lp), 0);
`endif
            if (e == 24) check("long_lp_e24", int'(lp), 0);
        end
`ifdef LONG_PRESS_EN
        check("long_pulses", longs, 1);
`else
        check("long_pulses", longs, 0);
`endif
        check("long_bwp_pulses", pulses, 1);
        check("long_count", int'(cnt), 3);
        key_n = 1'b1;
        repeat (10) tick();

        // Reset at edge 5 of a press.
        key_n = 1'b0;
        repeat (4) tick();
        rst   = 1'b1;
        key_n = 1'b1;
        tick();
        check("midrst_bwp", int'(bwp), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_long", int'(lp), 0);
        check("midrst_count", int'(cnt), 0);
        rst    = 1'b0;
        pulses = 0;
        repeat (12) tick();
        check("midrst_after_pulses", pulses, 0);
        check("midrst_after_count", int'(cnt), 0);

        // Reset during the pulse cycle.
        key_n = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 7) check("pulsrst_bwp_e7", int'(bwp), 1);
        end
        rst   = 1'b1;
        key_n = 1'b1;
        tick();
        check("pulsrst_bwp", int'(bwp), 0);
        check("pulsrst_level", int'(level), 0);
        check("pulsrst_count", int'(cnt), 0);
        rst    = 1'b0;
        pulses = 0;
        repeat (10) tick();
        check("pulsrst_after_pulses", pulses, 0);

        // 256 clean presses wrap press_count to 0.
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            key_n = 1'b0;
            repeat (9) tick();
            key_n = 1'b1;
            repeat (8) tick();
            if (i == 254) check("wrap_count_255", int'(cnt), 255);
        end
        check("wrap_count_0", int'(cnt), 0);
        check("wrap_pulses", pulses, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
